reg_dump_reader: RTL
====================

Name: reg_dump_reader

Overview:
- Sequential reader for the 32x32 register bank. On a start request it walks the bank's read address across a configured register range. It captures each combinational read result and streams it out as (index, data) beats over a valid/ready handshake.
- Sits beside the register bank and drives one read-address port. Used for debug dump, checkpointing, and comparing architectural state against the golden "data.txt" image in benches.

Parameters:
ADDR_W, 5, width of register index / bank read address
DATA_W, 32, width of register data
FIRST_REG, 0, first register index read (inclusive)
LAST_REG, 31, last register index read (inclusive); must satisfy FIRST_REG <= LAST_REG <= 2^ADDR_W-1, otherwise elaboration error

Ports:
clk  input  1  single clock; all state updates on rising edge
resetN  input  1  synchronous reset, active-low; sampled on rising clk edge
start  input  1  request a dump; honoured only in IDLE
abort  input  1  synchronous cancel of an in-progress dump
readReg  output  ADDR_W  read address to the bank's readReg port
readData  input  DATA_W  combinational read data from the bank's readData port
outValid  output  1  beat valid
outReady  input  1  downstream ready
outIndex  output  ADDR_W  register index of the current beat
outData  output  DATA_W  register contents of the current beat
busy  output  1  high in FETCH and SEND
done  output  1  one-cycle pulse after the last beat is accepted

Behaviour:
- Reset (resetN=0 at edge, overrides all other inputs): state=IDLE, idx=FIRST_REG, readReg=FIRST_REG, outValid=0, outIndex=0, outData=0, busy=0, done=0. Reset mid-dump drops the in-flight beat, and done does not pulse.
- readReg is driven from the idx register at all times, so it is stable for the whole cycle.
- States:
  - IDLE: if start=1, then idx<=FIRST_REG and go to FETCH. Otherwise stay.
  - FETCH: the bank presents Bank[idx] combinationally. At the edge: outData<=readData, outIndex<=idx, outValid<=1, go to SEND.
  - SEND: outValid=1. outData and outIndex are held stable while outReady=0.
    - On outReady=1 at the edge with idx==LAST_REG: outValid<=0, go to DONE.
    - On outReady=1 at the edge otherwise: outValid<=0, idx<=idx+1, go to FETCH.
  - DONE: done=1 for exactly this cycle, busy=0, idx<=FIRST_REG, go to IDLE.
- busy=1 exactly in FETCH and SEND. done is 1 only in DONE.
- Throughput: 2 cycles per beat minimum (FETCH+SEND). A full 32-register dump with outReady tied high takes 64 cycles from the start edge to the last beat acceptance, with the done pulse on cycle 65.
- The data word is captured in FETCH. A bank write to idx during SEND does not alter the outstanding beat. A write to a not-yet-read register is reflected in its later beat.
- start while busy or in DONE is ignored (no queuing).
- abort=1 at an edge in FETCH or SEND: go to IDLE, outValid<=0, idx<=FIRST_REG, no done. An accepted beat in that same cycle still counts as transferred.
- abort in IDLE/DONE has no effect. abort has priority over start in the same cycle.
- idx increment never wraps, because LAST_REG is checked before increment. With FIRST_REG==LAST_REG the block produces a single beat, then DONE.
- outValid never drops without a handshake, except on abort or reset.

Test Plan:
- Bank loaded with Bank[i]=i*0x01010101, outReady=1, pulse start -> 32 beats, outIndex 0..31, outData 0x00000000..0x1F1F1F1F, done pulse once, 65 cycles start-to-done.
- outReady=0 for 5 cycles on beat idx=3 -> outValid stays 1, outIndex=3 and outData=0x03030303 stable; resumes at idx=4 after ready.
- Mid-dump bank write Bank[10]=0xDEADBEEF while idx=4 -> beat 10 carries 0xDEADBEEF. Same write at idx=10 during SEND -> beat 10 carries the old value 0x0A0A0A0A.
- abort asserted at idx=7 in SEND with outReady=0 -> next cycle outValid=0, busy=0, no done. A new start dumps from index 0 again.
- resetN=0 for one edge during a dump at idx=20 -> all outputs take their reset values. start pulsed while busy is ignored, giving exactly one 32-beat sequence.
- FIRST_REG=LAST_REG=31 build -> one beat (31, Bank[31]), then done. Bad parameters (FIRST_REG=5, LAST_REG=4) fail elaboration.

Source files
------------

// File: rtl/reg_dump_reader.sv
// reg_dump_reader
// ----------------
// Walks a register bank's read address from FIRST_REG to LAST_REG when asked.
// Each word is captured from the bank's combinational read port and streamed
// out as an (index, data) beat over a valid/ready handshake. It is meant for
// debug dumps, checkpointing, and comparing architectural state in benches.
//
// Each register costs at least two cycles. In FETCH the bank read is
// captured. In SEND the beat is offered until downstream accepts it.
//
// Ports:
//   clk       single clock, all state changes on the rising edge
//   resetN    synchronous active-low reset
//   start     dump request, honoured only while idle
//   abort     synchronous cancel of a dump in progress
//   readReg   bank read address, driven straight from the index register
//   readData  combinational read data returned by the bank
//   outValid  beat valid
//   outReady  downstream ready
//   outIndex  register index of the current beat
//   outData   register contents of the current beat
//   busy      high while fetching or sending
//   done      one-cycle pulse after the last beat has been accepted
module reg_dump_reader #(
  parameter int ADDR_W    = 5,
  parameter int DATA_W    = 32,
  parameter int FIRST_REG = 0,
  parameter int LAST_REG  = 31
) (
  input  logic              clk,
  input  logic              resetN,
  input  logic              start,
  input  logic              abort,
  output logic [ADDR_W-1:0] readReg,
  input  logic [DATA_W-1:0] readData,
  output logic              outValid,
  input  logic              outReady,
  output logic [ADDR_W-1:0] outIndex,
  output logic [DATA_W-1:0] outData,
  output logic              busy,
  output logic              done
);

  // Reject a register range that is empty or that falls outside the bank.
  generate
    if (FIRST_REG < 0 || FIRST_REG > LAST_REG || LAST_REG > (1 << ADDR_W) - 1) begin : g_bad_range
      $error("reg_dump_reader: need 0 <= FIRST_REG <= LAST_REG <= 2**ADDR_W-1");
    end
  endgenerate

  localparam logic [ADDR_W-1:0] FIRST_IDX = ADDR_W'(FIRST_REG);
  localparam logic [ADDR_W-1:0] LAST_IDX  = ADDR_W'(LAST_REG);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_SEND,
    S_DONE
  } state_t;

  state_t            state_reg, state_next;
  logic [ADDR_W-1:0] idx_reg, idx_next;
  logic              out_valid_reg, out_valid_next;
  logic [ADDR_W-1:0] out_index_reg, out_index_next;
  logic [DATA_W-1:0] out_data_reg, out_data_next;

  always_ff @(posedge clk) begin
    if (!resetN) begin
      state_reg     <= S_IDLE;
      idx_reg       <= FIRST_IDX;
      out_valid_reg <= 1'b0;
      out_index_reg <= '0;
      out_data_reg  <= '0;
    end else begin
      state_reg     <= state_next;
      idx_reg       <= idx_next;
      out_valid_reg <= out_valid_next;
      out_index_reg <= out_index_next;
      out_data_reg  <= out_data_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    idx_next       = idx_reg;
    out_valid_next = out_valid_reg;
    out_index_next = out_index_reg;
    out_data_next  = out_data_reg;

    case (state_reg)
      S_IDLE: begin
        if (start) begin
          idx_next   = FIRST_IDX;
          state_next = S_FETCH;
        end
      end

      S_FETCH: begin
        if (abort) begin
          out_valid_next = 1'b0;
          idx_next       = FIRST_IDX;
          state_next     = S_IDLE;
        end else begin
          // Capture the word now. Later writes to this register must not
          // change the outstanding beat.
          out_data_next  = readData;
          out_index_next = idx_reg;
          out_valid_next = 1'b1;
          state_next     = S_SEND;
        end
      end

      S_SEND: begin
        if (abort) begin
          // A handshake that completes in this same cycle has already
          // reached downstream. Only the remaining registers are skipped.
          out_valid_next = 1'b0;
          idx_next       = FIRST_IDX;
          state_next     = S_IDLE;
        end else if (outReady) begin
          out_valid_next = 1'b0;
          // Test for the last register before incrementing, so the index
          // never wraps, even when LAST_REG is the top of the bank.
          if (idx_reg == LAST_IDX) begin
            state_next = S_DONE;
          end else begin
            idx_next   = idx_reg + ADDR_W'(1);
            state_next = S_FETCH;
          end
        end
      end

      S_DONE: begin
        idx_next   = FIRST_IDX;
        state_next = S_IDLE;
      end

      default: begin
        out_valid_next = 1'b0;
        idx_next       = FIRST_IDX;
        state_next     = S_IDLE;
      end
    endcase
  end

  assign readReg  = idx_reg;
  assign outValid = out_valid_reg;
  assign outIndex = out_index_reg;
  assign outData  = out_data_reg;
  assign busy     = (state_reg == S_FETCH) || (state_reg == S_SEND);
  assign done     = (state_reg == S_DONE);

endmodule
